// File: rtl/alu_serial_seq.sv
// Bit-serial N-bit ALU sequencer around a 1-bit ALU slice.
// Feeds one operand bit per clock (LSB first), carries between cycles and
// shifts each result bit into a result register; start/busy/done handshake.

// 1-bit ALU slice: 00 NOR, 01 XOR, 10 ADD, 11 SUB (B inverted inside the slice).
module alu1bit (
  input  logic       a,
  input  logic       b,
  input  logic       cin,
  input  logic [1:0] op,
  output logic       s,
  output logic       cout
);
  logic bx;

  // slice function; carry only meaningful for ADD/SUB
  always_comb begin
    bx   = (op == 2'b11) ? ~b : b;
    s    = 1'b0;
    cout = 1'b0;
    case (op)
      2'b00:   s = ~(a | b);
      2'b01:   s = a ^ b;
      default: begin
        s    = a ^ bx ^ cin;
        cout = (a & bx) | (a & cin) | (bx & cin);
      end
    endcase
  end
endmodule

module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_FIN = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MSB = CW'(WIDTH - 1);
  localparam logic [1:0]    OP_SUB  = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             cmsb_q, cmsb_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d, res_sh_q, res_sh_d;
  logic [1:0]       op_q, op_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;
  logic             sl_s, sl_cout;

  alu1bit u_slice (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .cin  (carry_q),
    .op   (op_q),
    .s    (sl_s),
    .cout (sl_cout)
  );

  // next-state: accept in IDLE, one bit per RUN edge, then a finalize edge into DONE
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    cmsb_d   = cmsb_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    res_sh_d = res_sh_q;
    op_d     = op_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          op_d    = op;
          carry_d = (op == OP_SUB);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (cnt_q == CNT_FIN) begin
          // all bits done: publish result and flags (arith flags only for ADD/SUB)
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = res_sh_q;
          cout_d   = op_q[1] & carry_q;
          ovf_d    = op_q[1] & (cmsb_q ^ carry_q);
          zero_d   = (res_sh_q == '0);
          state_d  = S_DONE;
        end else begin
          res_sh_d = {sl_s, res_sh_q[WIDTH-1:1]};
          a_sh_d   = a_sh_q >> 1;
          b_sh_d   = b_sh_q >> 1;
          carry_d  = sl_cout;
          // carry into the MSB is needed for signed overflow
          if (cnt_q == CNT_MSB) cmsb_d = carry_q;
          cnt_d    = cnt_q + 1'b1;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // state and registered outputs; reset discards any partial run
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      cmsb_q   <= 1'b0;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      op_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      cmsb_q   <= cmsb_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      res_sh_q <= res_sh_d;
      op_q     <= op_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;
endmodule

// File: tb/tb_alu_serial_seq.sv
// Bench for alu_serial_seq: fixed vector table, random vectors against an
// arithmetic model, plus mid-run start and mid-run reset sequences.
module tb_alu_serial_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [1:0]   op;
  logic [W-1:0] a, b;
  logic         busy, done, cout, ovf, zero;
  logic [W-1:0] result;

  int n_vec = 0;
  int n_err = 0;

  // expected output state held between operations
  logic [W-1:0] p_res;
  logic         p_c, p_o, p_z;

  typedef struct {
    logic [1:0]   op;
    logic [W-1:0] a, b, r;
    logic         c, o, z;
  } vec_t;
  vec_t tbl[5];

  alu_serial_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #50 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // reference: plain integer arithmetic on the operands
  task automatic model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                       output logic [W-1:0] r, output logic c, output logic v, output logic z);
    int unsigned sum;
    c = 1'b0; v = 1'b0;
    case (o)
      2'b00: r = ~(x | y);
      2'b01: r = x ^ y;
      2'b10: begin
        sum = int'(x) + int'(y);
        r = sum[W-1:0];
        c = (sum >= (1 << W));
        v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
      end
      default: begin
        r = x - y;
        c = (x >= y);
        v = (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
      end
    endcase
    z = (r == 0);
  endtask

  // Called just after a negedge. Issues one op; inj>0 pulses a stray start
  // with junk operands after that many edges.
  task automatic run_op(input string nm, input logic [1:0] o, input logic [W-1:0] x,
                        input logic [W-1:0] y, input logic [W-1:0] er, input logic ec,
                        input logic eo, input logic ez, input int inj);
    int edges;
    start = 1'b1; op = o; a = x; b = y;
    @(posedge clk); edges = 1;
    @(negedge clk);
    start = 1'b0; op = 2'($urandom); a = W'($urandom); b = W'($urandom);
    chk({nm, " busy"}, busy, 1'b1);
    chk({nm, " hold"}, result, p_res);
    while (edges < 30) begin
      @(posedge clk); edges++;
      @(negedge clk);
      start = (edges == inj);
      if (start) begin op = 2'b00; a = '0; end
      if (done) break;
    end
    start = 1'b0;
    chk({nm, " latency"}, edges, 10);
    chk({nm, " busy@done"}, busy, 1'b0);
    chk({nm, " result"}, result, er);
    chk({nm, " cout"}, cout, ec);
    chk({nm, " ovf"}, ovf, eo);
    chk({nm, " zero"}, zero, ez);
    p_res = er; p_c = ec; p_o = eo; p_z = ez;
    @(posedge clk); @(negedge clk);
    chk({nm, " pulse"}, done, 1'b0);
  endtask

  initial begin
    logic [W-1:0] rr;
    logic         rc, ro, rz;
    int           pulses;

    tbl[0] = '{op: 2'b10, a: 8'h7F, b: 8'h01, r: 8'h80, c: 1'b0, o: 1'b1, z: 1'b0};
    tbl[1] = '{op: 2'b11, a: 8'h05, b: 8'h07, r: 8'hFE, c: 1'b0, o: 1'b0, z: 1'b0};
    tbl[2] = '{op: 2'b11, a: 8'h80, b: 8'h01, r: 8'h7F, c: 1'b1, o: 1'b1, z: 1'b0};
    tbl[3] = '{op: 2'b00, a: 8'hF0, b: 8'h0C, r: 8'h03, c: 1'b0, o: 1'b0, z: 1'b0};
    tbl[4] = '{op: 2'b01, a: 8'hAA, b: 8'hAA, r: 8'h00, c: 1'b0, o: 1'b0, z: 1'b1};

    rst = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
    p_res = '0; p_c = 1'b0; p_o = 1'b0; p_z = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst result", result, 0);
    chk("rst flags", {cout, ovf, zero}, 3'b000);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      run_op($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b,
             tbl[i].r, tbl[i].c, tbl[i].o, tbl[i].z, 0);

    for (int i = 0; i < 30; i++) begin
      logic [1:0]   ro_op;
      logic [W-1:0] ra, rb;
      ro_op = 2'($urandom); ra = W'($urandom); rb = W'($urandom);
      if (i < 4) rb = ra;
      model(ro_op, ra, rb, rr, rc, ro, rz);
      run_op($sformatf("rnd%0d", i), ro_op, ra, rb, rr, rc, ro, rz, 0);
    end

    // stray start during RUN must be ignored, exactly one done pulse
    run_op("ign", 2'b10, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1, 4);
    pulses = 0;
    repeat (15) begin @(posedge clk); @(negedge clk); if (done) pulses++; end
    chk("ign extra done", pulses, 0);
    chk("ign idle busy", busy, 1'b0);

    // reset sampled on the 4th RUN edge aborts the operation
    start = 1'b1; op = 2'b10; a = 8'h12; b = 8'h34;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (3) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort result", result, 0);
    chk("abort flags", {cout, ovf, zero}, 3'b000);
    p_res = '0;
    model(2'b10, 8'h12, 8'h34, rr, rc, ro, rz);
    chk("model 12+34", rr, 8'h46);
    run_op("after abort", 2'b10, 8'h12, 8'h34, 8'h46, 1'b0, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/alu_serial_seq.md
Name: alu_serial_seq

Overview:
- Bit-serial N-bit ALU sequencer that feeds the team's 1-bit ALU slice (`alu1bit`) one bit per clock, LSB first.
- Registers the slice's carry between cycles and shifts each result bit into an N-bit result register.
- Sits directly upstream of the 1-bit slice: one `alu1bit` instance inside, driven from operand shift registers.
- Provides a start/busy/done handshake to the surrounding datapath.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  operation: 00 NOR, 01 XOR, 10 ADD, 11 SUB (A−B); sampled with start.
- a  input  WIDTH  operand A; sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- busy  output  1  high while bits are being processed (RUN).
- done  output  1  one-cycle pulse: result/flags just became valid.
- result  output  WIDTH  operation result, modulo 2^WIDTH.
- cout  output  1  final carry out (ADD/SUB); 0 for NOR/XOR.
- ovf  output  1  signed overflow (ADD/SUB); 0 for NOR/XOR.
- zero  output  1  result == 0.

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; busy=0, done=0, result=0, cout=0, ovf=0, zero=0; bit counter, carry register and shift registers cleared. Reset has priority over everything, including mid-RUN; a partial result is discarded.
- State IDLE:
  - start=1 at edge T: latch a, b, op into shift registers.
  - Initial carry = 1 for SUB, else 0. Counter = 0. Go to RUN.
  - busy is high in the cycle after T.
- State RUN: each edge processes bit i = counter.
  - Slice inputs: a_sh[0], b_sh[0], carry_reg, latched op.
  - Slice s shifts into result_sh at the MSB; a_sh/b_sh shift right; carry_reg <= slice cout.
  - The slice performs B inversion for SUB; the sequencer only supplies carry-in 1 on bit 0.
  - On bit WIDTH−1, capture the carry-in to the MSB for the overflow computation.
  - After WIDTH RUN edges, go to DONE.
- State DONE, one cycle:
  - done=1, busy=0; result, cout, ovf and zero are updated at the entry edge.
  - Next edge returns to IDLE regardless of start.
- Latency: start seen at edge T → done=1 in the cycle after edge T+WIDTH+1. For WIDTH=8 that is 10 edges from start to done-high.
- Output flags:
  - ovf = (carry into MSB) XOR cout, for ADD/SUB only.
  - cout and ovf are forced to 0 for NOR/XOR.
- SUB semantics: cout=1 means no borrow (A ≥ B unsigned).
- Output hold: result and flags hold their values from DONE until the next DONE or reset; they do not change during RUN.
- Input handling:
  - start while in RUN or DONE is ignored; no queuing.
  - start held high continuously restarts in the first IDLE cycle.
  - a, b, op changes after acceptance have no effect.
- Clock period must exceed the slice's worst-case combinational delay (≥40 time units with current primitive delays); benches use a period of 100.

Test Plan:
- WIDTH=8, ADD, a=0x7F, b=0x01 → result=0x80, cout=0, ovf=1, zero=0; done high exactly one cycle, 10 edges after start.
- SUB, a=0x05, b=0x07 → result=0xFE, cout=0, ovf=0.
- SUB, a=0x80, b=0x01 → result=0x7F, cout=1, ovf=1.
- NOR a=0xF0, b=0x0C → result=0x03, cout=0, ovf=0. Then XOR a=0xAA, b=0xAA → result=0x00, zero=1.
- ADD 0xFF+0x01 accepted; pulse start with a=0x00 op=NOR during RUN → ignored; result=0x00, cout=1, zero=1, single done pulse.
- Start ADD 0x12+0x34, assert rst at the 4th RUN edge → all outputs 0 and IDLE next cycle. A new start then yields ADD 0x12+0x34=0x46 with no residue from the aborted run.
